sincos_cordic: RTL and testbench
================================

SINCOS_CORDIC -- requirements
Module: sincos_cordic

Interface
REQ-001 The clock and reset ports SHALL be: clk  input  1  single clock, all logic on its rising edge.
REQ-002 The reset port SHALL be: rst  input  1  reset, synchronous, active-high.
REQ-003 Port: theta  input  signed `FLOAT_BITS  angle in fixed-point radians with `FLOAT_DCM_BITS fraction bits, as produced by the radians stage.
REQ-004 Port: in_valid  input  1  theta is valid.
REQ-005 Port: in_ready  output  1  block is idle and can accept theta.
REQ-006 Port: sin_out  output  signed `FLOAT_BITS  sine of theta, same fixed-point format.
REQ-007 Port: cos_out  output  signed `FLOAT_BITS  cosine of theta, same fixed-point format.
REQ-008 Port: out_valid  output  1  sin_out and cos_out are valid.
REQ-009 Port: out_ready  input  1  consumer accepts the result.

Function
REQ-010 Accept: the block SHALL accept theta on a clock edge where in_valid && in_ready, and SHALL register it.
REQ-011 FSM: the block SHALL implement states IDLE, REDUCE, ITER, DONE.
REQ-012 IDLE SHALL drive in_ready=1; on accept it SHALL go to REDUCE, or to ITER when reduction is compiled out.
REQ-013 REDUCE SHALL take 1 cycle: if theta >= PI, subtract 2*PI; if theta < -PI, add 2*PI; then if theta > PI/2, subtract PI and set negate; if theta < -PI/2, add PI and set negate; then go to ITER.
REQ-014 ITER SHALL run N = `FLOAT_DCM_BITS rotation-mode CORDIC micro-rotations, one per cycle, with x0 = K (0.607253 fixed-point), y0 = 0, z0 = reduced theta.
REQ-015 Iteration i SHALL use direction d = sign(z), with x' = x - d*(y>>>i), y' = y + d*(x>>>i), z' = z - d*atan(2^-i).
REQ-016 Internal x/y/z datapaths SHALL be `FLOAT_BITS+2 bits wide (2 guard bits), with arithmetic shifts and no saturation inside the loop.
REQ-017 The iteration counter SHALL be cleared on entry to ITER, and the state SHALL move to DONE after iteration N-1.
REQ-018 In DONE, cos_out and sin_out SHALL equal x and y truncated to `FLOAT_BITS, both negated when negate is set, and out_valid SHALL be 1.
REQ-019 DONE SHALL hold sin_out, cos_out and out_valid stable until out_ready=1, then go to IDLE on that edge.
REQ-020 Back-to-back: in_ready SHALL be 0 in REDUCE, ITER and DONE, so a new accept can occur no earlier than the cycle after the output handshake.
REQ-021 Latency: out_valid SHALL rise N+2 cycles after the accept edge with reduction compiled in, and N+1 cycles after it without reduction.
REQ-022 Accuracy: for theta in the contract range, |error| of each output SHALL be <= 4 LSB versus ideal.
REQ-023 For inputs outside the contract range, output values SHALL be unspecified, but the handshake SHALL still complete.
REQ-024 sin_out and cos_out SHALL only update on entry to DONE.

Reset
REQ-025 While rst=1, the state SHALL be IDLE, with in_ready=1 after reset, out_valid=0, sin_out=0, cos_out=0, counter=0 and negate=0.
REQ-026 rst asserted in any state, including mid-ITER or in DONE, SHALL abort the operation and discard the result, with out_valid=0 from the next edge.

Configuration
REQ-027 Macro SINCOS_RANGE_REDUCE_EN defined: REDUCE state SHALL be present and the contract range SHALL be [-2*PI, 2*PI).
REQ-028 Macro SINCOS_RANGE_REDUCE_EN undefined: REDUCE state and negate logic SHALL be absent, and the contract range SHALL be [-PI/2, PI/2].

Structure
REQ-029 Package cordic_pkg SHALL hold: the state enum type, iteration count N, CORDIC gain K, PI/2, PI and 2*PI constants, and the internal datapath width; all of these SHALL be derived from `FLOAT_BITS, `FLOAT_DCM_BITS and `PI in constants.h.
REQ-030 Sub-module sincos_atan_lut SHALL be combinational: input is the iteration index, output is atan(2^-i) in the internal fixed-point format, N entries.

Verification
REQ-031 theta=0 -> after N+2 cycles, cos_out = 1<<`FLOAT_DCM_BITS ±4 LSB and sin_out = 0 ±4 LSB.
REQ-032 theta = PI/2 (radians of 90) -> sin_out = 1.0 ±4 LSB and cos_out = 0 ±4 LSB.
REQ-033 Reduction on: theta = PI (radians of 180) -> cos_out = -1.0 ±4 LSB and sin_out = 0 ±4 LSB; theta = radians of -270 -> sin_out = 1.0 ±4 LSB.
REQ-034 out_ready held 0 for 5 cycles in DONE -> outputs stable, in_ready=0 throughout; on out_ready=1, IDLE follows with in_ready=1 on the next cycle.
REQ-035 rst pulsed for 1 cycle at iteration 3 -> out_valid=0 and in_ready=1 next cycle; a following theta=0 request then completes with the correct result.
REQ-036 Sweep of radians of -359..359 in 1-degree steps versus reference sin/cos -> all errors <= 4 LSB, each result arriving at exactly the REQ-021 latency.

Source files
------------

// File: rtl/cordic_pkg.sv
// rtl/cordic_pkg.sv - CORDIC state type, datapath widths and fixed-point constants
// Macro defaults stand in for constants.h when it is not already included.
`ifndef FLOAT_BITS
`define FLOAT_BITS 32
`endif
`ifndef FLOAT_DCM_BITS
`define FLOAT_DCM_BITS 16
`endif
`ifndef PI
`define PI 3.14159265358979323846
`endif

package cordic_pkg;

  localparam int DW    = `FLOAT_BITS;
  localparam int FB    = `FLOAT_DCM_BITS;
  localparam int N     = `FLOAT_DCM_BITS;
  localparam int GUARD = 2;
  localparam int IW    = DW + GUARD;
  localparam int IFB   = FB + GUARD;
  localparam int CNT_W = $clog2(N + 1);

  typedef enum logic [1:0] {IDLE, REDUCE, ITER, DONE} state_t;

  // Guard bits sit below the external LSB, so internal values carry IFB fraction bits.
  function automatic logic signed [IW-1:0] to_fix(input real v);
    return IW'($rtoi(v * (2.0 ** IFB) + ((v >= 0.0) ? 0.5 : -0.5)));
  endfunction

  function automatic real cordic_gain(input int n);
    real k;
    k = 1.0;
    for (int i = 0; i < n; i++) k = k / $sqrt(1.0 + 2.0 ** (-2 * i));
    return k;
  endfunction

  function automatic logic signed [IW-1:0] atan_fix(input int i);
    return to_fix($atan(2.0 ** (-i)));
  endfunction

  localparam logic signed [IW-1:0] K_FIX       = to_fix(cordic_gain(N));
  localparam logic signed [IW-1:0] HALF_PI_FIX = to_fix(`PI / 2.0);
  localparam logic signed [IW-1:0] PI_FIX      = to_fix(`PI);
  localparam logic signed [IW-1:0] TWO_PI_FIX  = to_fix(2.0 * `PI);

endpackage

// File: rtl/sincos_atan_lut.sv
// rtl/sincos_atan_lut.sv - combinational atan(2^-i) table in the internal fixed-point format
module sincos_atan_lut
  import cordic_pkg::*;
(
  input  logic [CNT_W-1:0]     idx,
  output logic signed [IW-1:0] angle
);

  always_comb begin
    angle = '0;
    for (int i = 0; i < N; i++) begin
      if (idx == CNT_W'(i)) angle = atan_fix(i);
    end
  end

endmodule

// File: rtl/sincos_cordic.sv
// rtl/sincos_cordic.sv - iterative rotation-mode CORDIC sine/cosine with valid/ready handshakes
// SINCOS_RANGE_REDUCE_EN adds the REDUCE state, widening the input range to [-2*PI, 2*PI).
module sincos_cordic
  import cordic_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic signed [DW-1:0] theta,
  input  logic                 in_valid,
  output logic                 in_ready,
  output logic signed [DW-1:0] sin_out,
  output logic signed [DW-1:0] cos_out,
  output logic                 out_valid,
  input  logic                 out_ready
);

  state_t                state, state_nxt;
  logic signed [IW-1:0]  x, y, z, atan_q, lut_angle;
  logic signed [IW-1:0]  x_nxt, y_nxt, z_nxt, x_sh, y_sh;
  logic [CNT_W-1:0]      cnt, shamt;
  logic                  accept, last_iter;
  logic signed [DW-1:0]  sin_trunc, cos_trunc;

  sincos_atan_lut u_atan_lut (.idx(cnt), .angle(lut_angle));

  assign accept    = in_valid && in_ready;
  assign last_iter = (state == ITER) && (cnt == CNT_W'(N));

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
`ifdef SINCOS_RANGE_REDUCE_EN
        if (in_valid) state_nxt = REDUCE;
`else
        if (in_valid) state_nxt = ITER;
`endif
      end
`ifdef SINCOS_RANGE_REDUCE_EN
      REDUCE: state_nxt = ITER;
`endif
      ITER: if (last_iter) state_nxt = DONE;
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // cnt==0 only prefetches atan(2^0); iteration i runs while cnt == i+1.
  assign shamt = cnt - CNT_W'(1);
  assign x_sh  = x >>> shamt;
  assign y_sh  = y >>> shamt;

  always_comb begin
    x_nxt = x - y_sh;
    y_nxt = y + x_sh;
    z_nxt = z - atan_q;
    if (z[IW-1]) begin
      x_nxt = x + y_sh;
      y_nxt = y - x_sh;
      z_nxt = z + atan_q;
    end
  end

  assign cos_trunc = DW'(x_nxt >>> GUARD);
  assign sin_trunc = DW'(y_nxt >>> GUARD);

`ifdef SINCOS_RANGE_REDUCE_EN
  logic signed [IW-1:0] z_wrap, z_red;
  logic                 negate, neg_red;

  // Fold into [-PI, PI), then into [-PI/2, PI/2] using sin/cos(t-PI) = -sin/cos(t).
  always_comb begin
    z_wrap = z;
    if (z >= PI_FIX) z_wrap = z - TWO_PI_FIX;
    else if (z < -PI_FIX) z_wrap = z + TWO_PI_FIX;
    z_red   = z_wrap;
    neg_red = 1'b0;
    if (z_wrap > HALF_PI_FIX) begin
      z_red   = z_wrap - PI_FIX;
      neg_red = 1'b1;
    end else if (z_wrap < -HALF_PI_FIX) begin
      z_red   = z_wrap + PI_FIX;
      neg_red = 1'b1;
    end
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      x       <= '0;
      y       <= '0;
      z       <= '0;
      atan_q  <= '0;
      cnt     <= '0;
      sin_out <= '0;
      cos_out <= '0;
`ifdef SINCOS_RANGE_REDUCE_EN
      negate  <= 1'b0;
`endif
    end else begin
      state <= state_nxt;
      if (accept) begin
        x   <= K_FIX;
        y   <= '0;
        z   <= IW'(theta) <<< GUARD;
        cnt <= '0;
`ifdef SINCOS_RANGE_REDUCE_EN
        negate <= 1'b0;
`endif
      end
`ifdef SINCOS_RANGE_REDUCE_EN
      if (state == REDUCE) begin
        z      <= z_red;
        negate <= neg_red;
        cnt    <= '0;
      end
`endif
      if (state == ITER) begin
        atan_q <= lut_angle;
        cnt    <= cnt + CNT_W'(1);
        if (cnt != '0) begin
          x <= x_nxt;
          y <= y_nxt;
          z <= z_nxt;
        end
        if (last_iter) begin
`ifdef SINCOS_RANGE_REDUCE_EN
          sin_out <= negate ? -sin_trunc : sin_trunc;
          cos_out <= negate ? -cos_trunc : cos_trunc;
`else
          sin_out <= sin_trunc;
          cos_out <= cos_trunc;
`endif
        end
      end
    end
  end

endmodule

// File: tb/tb_sincos_cordic.sv
// tb/tb_sincos_cordic.sv - self-checking bench for sincos_cordic (directed table, corner sequences, degree sweep)
`ifndef FLOAT_BITS
`define FLOAT_BITS 32
`endif
`ifndef FLOAT_DCM_BITS
`define FLOAT_DCM_BITS 16
`endif
`ifndef PI
`define PI 3.14159265358979323846
`endif

module tb_sincos_cordic;

  localparam int  TDW = `FLOAT_BITS;
  localparam int  TFB = `FLOAT_DCM_BITS;
  localparam int  NIT = `FLOAT_DCM_BITS;
`ifdef SINCOS_RANGE_REDUCE_EN
  localparam int  LAT     = NIT + 2;
  localparam int  DEG_MAX = 359;
`else
  localparam int  LAT     = NIT + 1;
  localparam int  DEG_MAX = 90;
`endif
  localparam real ONE = 2.0 ** TFB;
  localparam real TOL = 4.0;

  logic clk = 1'b0;
  logic rst, in_valid, in_ready, out_valid, out_ready;
  logic signed [TDW-1:0] theta, sin_out, cos_out;

  int checks = 0;
  int errors = 0;

  typedef struct {
    string name;
    int    th;
    int    es;
    int    ec;
  } vec_t;
  vec_t vecs[$];

  sincos_cordic dut (
    .clk(clk), .rst(rst), .theta(theta), .in_valid(in_valid), .in_ready(in_ready),
    .sin_out(sin_out), .cos_out(cos_out), .out_valid(out_valid), .out_ready(out_ready)
  );

  always #5 clk = ~clk;

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic chk_eq(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic chk_near(input string name, input longint act, input real ref_val);
    real e;
    checks++;
    e = real'(act) - ref_val;
    if (e < 0.0) e = -e;
    if (e > TOL) begin
      errors++;
      $display("FAIL %s: got %0d expected %0.2f within 4 LSB", name, act, ref_val);
    end
  endtask

  task automatic add_vec(input string name, input int th, input int es, input int ec);
    vec_t v;
    v.name = name;
    v.th   = th;
    v.es   = es;
    v.ec   = ec;
    vecs.push_back(v);
  endtask

  // Ends on the negedge right after the accept edge.
  task automatic start_op(input logic signed [TDW-1:0] th);
    @(negedge clk);
    chk_eq("in_ready_idle", in_ready, 1);
    theta    = th;
    in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    chk_eq("in_ready_busy", in_ready, 0);
  endtask

  // Counts clock edges from the accept edge until out_valid is seen.
  task automatic wait_valid();
    int lat;
    lat = 0;
    for (int c = 0; c < 4 * LAT; c++) begin
      if (out_valid) break;
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
    chk_eq("out_valid_seen", out_valid, 1);
    chk_eq("latency", lat, LAT);
  endtask

  task automatic finish_op();
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    chk_eq("out_valid_after_hs", out_valid, 0);
    chk_eq("in_ready_after_hs", in_ready, 1);
  endtask

  task automatic run_op(input logic signed [TDW-1:0] th,
                        output logic signed [TDW-1:0] s, output logic signed [TDW-1:0] c);
    start_op(th);
    wait_valid();
    s = sin_out;
    c = cos_out;
    finish_op();
  endtask

  initial begin
    logic signed [TDW-1:0] s, c, s0, c0;
    int seen, th;
    real r;

    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    theta     = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_eq("rst_in_ready", in_ready, 1);
    chk_eq("rst_out_valid", out_valid, 0);
    chk_eq("rst_sin", sin_out, 0);
    chk_eq("rst_cos", cos_out, 0);
    rst = 1'b0;

    // Hand-computed values for 16 fraction bits; 1.0 = 65536.
    add_vec("zero",     0,       0,      65536);
    add_vec("pi_2",     102943,  65536,  0);
    add_vec("m_pi_2",   -102943, -65536, 0);
    add_vec("pi_6",     34315,   32768,  56756);
    add_vec("pi_3",     68629,   56756,  32768);
    add_vec("m_pi_4",   -51472,  -46341, 46341);
`ifdef SINCOS_RANGE_REDUCE_EN
    add_vec("pi",       205887,  0,      -65536);
    add_vec("m_pi",     -205887, 0,      -65536);
    add_vec("m_270deg", -308831, 65536,  0);
    add_vec("300deg",   343145,  -56756, 32768);
`endif

    foreach (vecs[i]) begin
      run_op(vecs[i].th, s, c);
      chk_near({vecs[i].name, "_sin"}, s, real'(vecs[i].es));
      chk_near({vecs[i].name, "_cos"}, c, real'(vecs[i].ec));
    end

    // Consumer stalls for 5 cycles in DONE.
    start_op(34315);
    wait_valid();
    s0 = sin_out;
    c0 = cos_out;
    repeat (5) begin
      @(posedge clk);
      @(negedge clk);
      chk_eq("stall_out_valid", out_valid, 1);
      chk_eq("stall_in_ready", in_ready, 0);
      chk_eq("stall_sin_stable", sin_out, s0);
      chk_eq("stall_cos_stable", cos_out, c0);
    end
    chk_near("stall_sin", s0, 32768.0);
    chk_near("stall_cos", c0, 56756.0);
    finish_op();

    // Reset pulse on the edge that would perform iteration 3.
    start_op(68629);
    repeat (LAT - NIT + 3) begin
      @(posedge clk);
      @(negedge clk);
    end
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    chk_eq("midrst_out_valid", out_valid, 0);
    chk_eq("midrst_in_ready", in_ready, 1);
    seen = 0;
    repeat (LAT + 2) begin
      @(posedge clk);
      @(negedge clk);
      if (out_valid) seen++;
    end
    chk_eq("midrst_no_stale_result", seen, 0);
    run_op(0, s, c);
    chk_near("midrst_zero_sin", s, 0.0);
    chk_near("midrst_zero_cos", c, 65536.0);

    // Reset while holding a result in DONE.
    start_op(-51472);
    wait_valid();
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    chk_eq("donerst_out_valid", out_valid, 0);
    chk_eq("donerst_in_ready", in_ready, 1);

    for (int deg = -DEG_MAX; deg <= DEG_MAX; deg++) begin
      r  = real'(deg) * `PI / 180.0 * ONE;
      th = $rtoi(r + ((r >= 0.0) ? 0.5 : -0.5));
      run_op(th, s, c);
      chk_near($sformatf("sweep_sin_deg%0d", deg), s, $sin(real'(th) / ONE) * ONE);
      chk_near($sformatf("sweep_cos_deg%0d", deg), c, $cos(real'(th) / ONE) * ONE);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
